hqm_aw_rmw_mem_resp: RTL and testbench

Memory-side responder for the RMW pipe memory interface. It owns a DEPTH x WIDTH storage array and accepts independent read and write commands each cycle. Read data returns with fixed latency RD_LAT. After every reset it runs a self-initialisation sequence that zeroes the array. It is instantiated opposite a 4-stage RMW pipe, in place of a plain RAM wrapper, for blocks that need init and error reporting.

---
 rtl/hqm_aw_rmw_mem_resp.sv | 183 ++++++++++++++++++
 tb/tb_hqm_aw_rmw_mem_resp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hqm_aw_rmw_mem_resp.sv
// Memory-side responder for the RMW pipe: self-zeroing DEPTH x WIDTH array, fixed-latency reads, sticky errors.
// Parity storage/checking is enabled by defining HQM_AW_RMW_MEM_RESP_PARITY_EN.
//
// state | meaning
// INIT  | writing zero to array[init_cnt] each cycle; commands rejected and flagged
// READY | servicing read/write commands; left only through rst
module hqm_aw_rmw_mem_resp #(
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_FWD  = 0,
    parameter int DEPTHB2 = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_write,
    input  logic [DEPTHB2-1:0] mem_write_addr,
    input  logic [WIDTH-1:0]   mem_write_data,
    input  logic               mem_read,
    input  logic [DEPTHB2-1:0] mem_read_addr,
    output logic [WIDTH-1:0]   mem_read_data,
    output logic               mem_read_data_v,
    output logic               init_done,
    output logic               err_init_access,
    output logic               err_oor,
    output logic               err_par,
    input  logic               inj_par
);

`ifdef HQM_AW_RMW_MEM_RESP_PARITY_EN
    localparam int AW = WIDTH + 1;
`else
    localparam int AW = WIDTH;
`endif
    localparam logic [DEPTHB2-1:0] LAST_ADDR = DEPTHB2'(DEPTH - 1);

    generate
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
            $error("hqm_aw_rmw_mem_resp: RD_LAT must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTHB2-1:0] init_cnt_q, init_cnt_d;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign init_done = (state_q == READY);

    // Out-of-range addresses only exist when DEPTH leaves part of the address space unused.
    logic wr_oor, rd_oor;
    generate
        if (DEPTH == (1 << DEPTHB2)) begin : g_pow2
            assign wr_oor = 1'b0;
            assign rd_oor = 1'b0;
        end else begin : g_npow2
            localparam logic [DEPTHB2-1:0] DEPTH_L = DEPTHB2'(DEPTH);
            assign wr_oor = (mem_write_addr >= DEPTH_L);
            assign rd_oor = (mem_read_addr >= DEPTH_L);
        end
    endgenerate

    logic ready, wr_fire, rd_fire;
    assign ready   = (state_q == READY);
    assign wr_fire = ready & mem_write & ~wr_oor;
    assign rd_fire = ready & mem_read;

    logic [AW-1:0] wr_word;
`ifdef HQM_AW_RMW_MEM_RESP_PARITY_EN
    assign wr_word = {(^mem_write_data) ^ inj_par, mem_write_data};
`else
    logic unused_inj_par;
    assign wr_word        = mem_write_data;
    assign unused_inj_par = inj_par;
`endif

    // Zero with even parity is all-zero, so INIT needs no parity term.
    logic [AW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[init_cnt_q] <= '0;
        end else if (wr_fire) begin
            mem[mem_write_addr] <= wr_word;
        end
    end

    logic [AW-1:0] rd_word;
    always_comb begin
        rd_word = mem[mem_read_addr];
        if ((WR_FWD != 0) && wr_fire && (mem_write_addr == mem_read_addr)) begin
            rd_word = wr_word;
        end
        if (rd_oor) begin
            rd_word = '0;
        end
    end

    logic          out_v_d;
    logic [AW-1:0] out_word_d;
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s1_v;
            logic [AW-1:0] s1_word;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_v    <= 1'b0;
                    s1_word <= '0;
                end else begin
                    s1_v <= rd_fire;
                    if (rd_fire) begin
                        s1_word <= rd_word;
                    end
                end
            end
            assign out_v_d    = s1_v;
            assign out_word_d = s1_word;
        end else begin : g_lat1
            assign out_v_d    = rd_fire;
            assign out_word_d = rd_word;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_read_data_v <= 1'b0;
            mem_read_data   <= '0;
            err_init_access <= 1'b0;
            err_oor         <= 1'b0;
        end else begin
            mem_read_data_v <= out_v_d;
            if (out_v_d) begin
                mem_read_data <= out_word_d[WIDTH-1:0];
            end
            if ((state_q == INIT) && (mem_read || mem_write)) begin
                err_init_access <= 1'b1;
            end
            if (ready && ((mem_write && wr_oor) || (mem_read && rd_oor))) begin
                err_oor <= 1'b1;
            end
        end
    end

`ifdef HQM_AW_RMW_MEM_RESP_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_par <= 1'b0;
        end else if (out_v_d && (^out_word_d)) begin
            err_par <= 1'b1;
        end
    end
`else
    assign err_par = 1'b0;
`endif

endmodule

// File: tb/tb_hqm_aw_rmw_mem_resp.sv
// Bench for hqm_aw_rmw_mem_resp: two instances (8-deep RD_LAT=1 WR_FWD=0, 6-deep RD_LAT=2 WR_FWD=1)
// driven in lockstep and compared against a behavioural memory model with a latency delay line.
module tb_hqm_aw_rmw_mem_resp;
    localparam int W = 32;
`ifdef HQM_AW_RMW_MEM_RESP_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         wr [2];
    logic [2:0]   wa [2];
    logic [W-1:0] wd [2];
    logic         rd [2];
    logic [2:0]   ra [2];
    logic         inj [2];
    logic [W-1:0] rdata [2];
    logic         rv [2];
    logic         idone [2];
    logic         eia [2];
    logic         eoor [2];
    logic         epar [2];

    hqm_aw_rmw_mem_resp #(.DEPTH(8), .WIDTH(W), .RD_LAT(1), .WR_FWD(0)) dut_a (
        .clk(clk), .rst(rst),
        .mem_write(wr[0]), .mem_write_addr(wa[0]), .mem_write_data(wd[0]),
        .mem_read(rd[0]), .mem_read_addr(ra[0]),
        .mem_read_data(rdata[0]), .mem_read_data_v(rv[0]), .init_done(idone[0]),
        .err_init_access(eia[0]), .err_oor(eoor[0]), .err_par(epar[0]), .inj_par(inj[0])
    );

    hqm_aw_rmw_mem_resp #(.DEPTH(6), .WIDTH(W), .RD_LAT(2), .WR_FWD(1)) dut_b (
        .clk(clk), .rst(rst),
        .mem_write(wr[1]), .mem_write_addr(wa[1]), .mem_write_data(wd[1]),
        .mem_read(rd[1]), .mem_read_addr(ra[1]),
        .mem_read_data(rdata[1]), .mem_read_data_v(rv[1]), .init_done(idone[1]),
        .err_init_access(eia[1]), .err_oor(eoor[1]), .err_par(epar[1]), .inj_par(inj[1])
    );

    int n_cmp = 0;
    int n_fail = 0;

    // reference model
    int           dep [2] = '{8, 6};
    int           lat [2] = '{1, 2};
    bit           fwd [2] = '{1'b0, 1'b1};
    int           edges;
    logic [W-1:0] mm  [2][8];
    bit           pb  [2][8];
    bit           pv  [2][2];
    logic [W-1:0] pd  [2][2];
    bit           pbd [2][2];
    bit           exp_v [2], exp_done [2], exp_ia [2], exp_oor [2], exp_par [2];
    logic [W-1:0] exp_d [2];

    task automatic set_idle();
        for (int d = 0; d < 2; d++) begin
            wr[d] = 1'b0; wa[d] = '0; wd[d] = '0;
            rd[d] = 1'b0; ra[d] = '0; inj[d] = 1'b0;
        end
    endtask

    task automatic model_reset();
        edges = 0;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 8; a++) begin
                mm[d][a] = '0; pb[d][a] = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                pv[d][i] = 1'b0; pd[d][i] = '0; pbd[d][i] = 1'b0;
            end
            exp_v[d] = 1'b0; exp_d[d] = '0; exp_done[d] = 1'b0;
            exp_ia[d] = 1'b0; exp_oor[d] = 1'b0; exp_par[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        #2;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock edge: apply the commands currently driven to the model, then settle.
    task automatic step();
        bit ready, nv, nb;
        logic [W-1:0] nd;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            ready = (edges >= dep[d]);
            nv = 1'b0; nb = 1'b0; nd = '0;
            if (!ready) begin
                if (rd[d] || wr[d]) exp_ia[d] = 1'b1;
            end else begin
                if (rd[d]) begin
                    nv = 1'b1;
                    if (int'(ra[d]) >= dep[d]) exp_oor[d] = 1'b1;
                    else if (fwd[d] && wr[d] && wa[d] == ra[d]) begin nd = wd[d]; nb = inj[d]; end
                    else begin nd = mm[d][ra[d]]; nb = pb[d][ra[d]]; end
                end
                if (wr[d]) begin
                    if (int'(wa[d]) >= dep[d]) exp_oor[d] = 1'b1;
                    else begin mm[d][wa[d]] = wd[d]; pb[d][wa[d]] = inj[d]; end
                end
            end
            for (int i = lat[d] - 1; i > 0; i--) begin
                pv[d][i] = pv[d][i-1]; pd[d][i] = pd[d][i-1]; pbd[d][i] = pbd[d][i-1];
            end
            pv[d][0] = nv; pd[d][0] = nd; pbd[d][0] = nb;
            exp_v[d] = pv[d][lat[d]-1];
            if (exp_v[d]) begin
                exp_d[d] = pd[d][lat[d]-1];
                if (PAR && pbd[d][lat[d]-1]) exp_par[d] = 1'b1;
            end
            exp_done[d] = (edges + 1 >= dep[d]);
        end
        edges++;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (rdata[d] !== '0)   begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h expected 0", d, rdata[d]); end
            n_cmp++; if (rv[d] !== 1'b0)    begin n_fail++; $display("FAIL reset_valid dut%0d: got %b expected 0", d, rv[d]); end
            n_cmp++; if (idone[d] !== 1'b0) begin n_fail++; $display("FAIL reset_init_done dut%0d: got %b expected 0", d, idone[d]); end
            n_cmp++; if ({eia[d], eoor[d], epar[d]} !== 3'b000) begin
                n_fail++; $display("FAIL reset_flags dut%0d: got %b expected 000", d, {eia[d], eoor[d], epar[d]});
            end
        end
    endtask

    task automatic test_init();
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (idone[d] !== exp_done[d]) begin
                    n_fail++; $display("FAIL init_done dut%0d cycle %0d: got %b expected %b", d, c, idone[d], exp_done[d]);
                end
            end
        end
        for (int a = 0; a < 10; a++) begin
            rd[0] = (a < 8); ra[0] = a[2:0];
            rd[1] = (a < 6); ra[1] = a[2:0];
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++; if (rv[d] !== exp_v[d]) begin n_fail++; $display("FAIL init_read_valid dut%0d step %0d: got %b expected %b", d, a, rv[d], exp_v[d]); end
                n_cmp++; if (rdata[d] !== '0) begin n_fail++; $display("FAIL init_read_zero dut%0d step %0d: got %h expected 0", d, a, rdata[d]); end
            end
        end
    endtask

    task automatic test_write_read();
        int nval [2];
        set_idle();
        for (int d = 0; d < 2; d++) begin wr[d] = 1'b1; wa[d] = 3'd3; wd[d] = 32'hDEADBEEF; end
        step();
        set_idle();
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b1; ra[d] = 3'd3; end
        step();
        set_idle();
        n_cmp++; if (rv[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat1_read: got v=%b %h expected v=1 deadbeef", rv[0], rdata[0]); end
        n_cmp++; if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL lat2_early_valid: got %b expected 0", rv[1]); end
        step();
        n_cmp++; if (rv[1] !== 1'b1 || rdata[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat2_read: got v=%b %h expected v=1 deadbeef", rv[1], rdata[1]); end
        n_cmp++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL lat1_valid_drop: got %b expected 0", rv[0]); end
        nval = '{0, 0};
        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 2; d++) begin rd[d] = (k < 4); ra[d] = 3'(k); end
            step();
            for (int d = 0; d < 2; d++) begin
                if (rv[d] === 1'b1) nval[d]++;
                n_cmp++; if (rv[d] !== exp_v[d] || rdata[d] !== exp_d[d]) begin
                    n_fail++; $display("FAIL b2b_read dut%0d step %0d: got v=%b %h expected v=%b %h", d, k, rv[d], rdata[d], exp_v[d], exp_d[d]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (nval[d] != 4) begin n_fail++; $display("FAIL b2b_count dut%0d: got %0d expected 4", d, nval[d]); end
        end
        set_idle();
    endtask

    task automatic test_collision();
        set_idle();
        for (int d = 0; d < 2; d++) begin wr[d] = 1'b1; wa[d] = 3'd5; wd[d] = 32'h11; end
        step();
        for (int d = 0; d < 2; d++) begin wd[d] = 32'h22; rd[d] = 1'b1; ra[d] = 3'd5; end
        step();
        set_idle();
        n_cmp++; if (rv[0] !== 1'b1 || rdata[0] !== 32'h11) begin n_fail++; $display("FAIL collision_old dut0: got v=%b %h expected v=1 11", rv[0], rdata[0]); end
        step();
        n_cmp++; if (rv[1] !== 1'b1 || rdata[1] !== 32'h22) begin n_fail++; $display("FAIL collision_fwd dut1: got v=%b %h expected v=1 22", rv[1], rdata[1]); end
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b1; ra[d] = 3'd5; end
        step();
        set_idle();
        n_cmp++; if (rdata[0] !== 32'h22) begin n_fail++; $display("FAIL collision_after dut0: got %h expected 22", rdata[0]); end
        step();
        n_cmp++; if (rdata[1] !== 32'h22) begin n_fail++; $display("FAIL collision_after dut1: got %h expected 22", rdata[1]); end
    endtask

    task automatic test_oor();
        set_idle();
        for (int d = 0; d < 2; d++) begin wr[d] = 1'b1; wa[d] = 3'd7; wd[d] = 32'hFF; end
        step();
        set_idle();
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b1; ra[d] = 3'd7; end
        step();
        set_idle();
        n_cmp++; if (rdata[0] !== 32'hFF) begin n_fail++; $display("FAIL oor_inrange_dut0: got %h expected ff", rdata[0]); end
        step();
        n_cmp++; if (rv[1] !== 1'b1 || rdata[1] !== '0) begin n_fail++; $display("FAIL oor_read dut1: got v=%b %h expected v=1 0", rv[1], rdata[1]); end
        n_cmp++; if (eoor[1] !== 1'b1) begin n_fail++; $display("FAIL oor_flag dut1: got %b expected 1", eoor[1]); end
        n_cmp++; if (eoor[0] !== 1'b0) begin n_fail++; $display("FAIL oor_flag dut0: got %b expected 0", eoor[0]); end
        for (int k = 0; k < 8; k++) begin
            rd[1] = (k < 6); ra[1] = 3'(k);
            step();
            n_cmp++; if (rv[1] !== exp_v[1] || rdata[1] !== exp_d[1]) begin
                n_fail++; $display("FAIL oor_neighbours step %0d: got v=%b %h expected v=%b %h", k, rv[1], rdata[1], exp_v[1], exp_d[1]);
            end
        end
        set_idle();
    endtask

    task automatic test_parity();
        set_idle();
        for (int d = 0; d < 2; d++) begin wr[d] = 1'b1; wa[d] = 3'd0; wd[d] = 32'h5A; end
        step();
        set_idle();
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b1; ra[d] = 3'd0; end
        step();
        set_idle();
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (epar[d] !== 1'b0) begin n_fail++; $display("FAIL parity_clean dut%0d: got %b expected 0", d, epar[d]); end
        end
        for (int d = 0; d < 2; d++) begin wr[d] = 1'b1; wa[d] = 3'd1; wd[d] = 32'hA5; inj[d] = 1'b1; end
        step();
        set_idle();
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b1; ra[d] = 3'd1; end
        step();
        set_idle();
        n_cmp++; if (rdata[0] !== 32'hA5 || epar[0] !== PAR) begin n_fail++; $display("FAIL parity_inj dut0: got %h par=%b expected a5 par=%b", rdata[0], epar[0], PAR); end
        step();
        n_cmp++; if (rdata[1] !== 32'hA5 || epar[1] !== PAR) begin n_fail++; $display("FAIL parity_inj dut1: got %h par=%b expected a5 par=%b", rdata[1], epar[1], PAR); end
    endtask

    task automatic test_init_access();
        int rise [2];
        do_reset();
        step();
        for (int d = 0; d < 2; d++) begin wr[d] = 1'b1; wa[d] = 3'd2; wd[d] = 32'h55; end
        step();
        set_idle();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (eia[d] !== 1'b1) begin n_fail++; $display("FAIL init_access_flag dut%0d: got %b expected 1", d, eia[d]); end
        end
        repeat (6) step();
        for (int d = 0; d < 2; d++) begin rd[d] = 1'b1; ra[d] = 3'd2; end
        step();
        set_idle();
        step();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (rdata[d] !== '0 || idone[d] !== 1'b1) begin n_fail++; $display("FAIL init_access_array dut%0d: got %h done=%b expected 0 done=1", d, rdata[d], idone[d]); end
        end
        // reset in the middle of INIT
        do_reset();
        step();
        wr[0] = 1'b1;
        step();
        set_idle();
        step();
        rst = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (eia[d] !== 1'b0 || idone[d] !== 1'b0) begin n_fail++; $display("FAIL midinit_reset dut%0d: got ia=%b done=%b expected 0 0", d, eia[d], idone[d]); end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rise = '{0, 0};
        for (int c = 1; c <= 20; c++) begin
            step();
            for (int d = 0; d < 2; d++) if (rise[d] == 0 && idone[d] === 1'b1) rise[d] = c;
        end
        n_cmp++; if (rise[0] != 8) begin n_fail++; $display("FAIL midinit_restart dut0: got %0d cycles expected 8", rise[0]); end
        n_cmp++; if (rise[1] != 6) begin n_fail++; $display("FAIL midinit_restart dut1: got %0d cycles expected 6", rise[1]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                wr[d]  = 1'($urandom_range(0, 1));
                wa[d]  = 3'($urandom_range(0, 7));
                wd[d]  = $urandom;
                rd[d]  = 1'($urandom_range(0, 1));
                ra[d]  = ($urandom_range(0, 3) == 0) ? wa[d] : 3'($urandom_range(0, 7));
                inj[d] = ($urandom_range(0, 15) == 0);
            end
            step();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (rv[d] !== exp_v[d] || rdata[d] !== exp_d[d] || idone[d] !== exp_done[d] ||
                    eia[d] !== exp_ia[d] || eoor[d] !== exp_oor[d] || epar[d] !== exp_par[d]) begin
                    n_fail++;
                    $display("FAIL random dut%0d cycle %0d: got v=%b d=%h done=%b ia=%b oor=%b par=%b expected v=%b d=%h done=%b ia=%b oor=%b par=%b",
                             d, c, rv[d], rdata[d], idone[d], eia[d], eoor[d], epar[d],
                             exp_v[d], exp_d[d], exp_done[d], exp_ia[d], exp_oor[d], exp_par[d]);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        test_reset();
        test_init();
        test_write_read();
        test_collision();
        test_oor();
        test_parity();
        test_init_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
